// File: rtl/adpll_phase_det.sv
// adpll_phase_det: counter-based phase/frequency detector for the ADPLL loop.
// Synchronises ref_in and fb_in into clk, measures the clk-cycle distance
// between each reference edge and the nearest feedback edge, and emits one
// signed, registered error sample per measurement with a one-cycle strobe.
// Optional lock detector is compiled in when ADPLL_LOCK_DET_EN is defined;
// otherwise locked is constant 0.
module adpll_phase_det #(
  parameter int ERR_W       = 8,
  parameter int TIMEOUT     = 100,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic [ERR_W-1:0] phase_err,
  output logic             err_valid,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FB  = 2'd1,
    WAIT_REF = 2'd2
  } state_t;

  // Largest positive error; the most negative code is never produced.
  localparam logic [ERR_W-1:0] MAX_POS   = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic [ERR_W-1:0] CNT_ZERO  = '0;
  localparam logic [ERR_W-1:0] CNT_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] CNT_SAT   = '1;
  localparam logic [ERR_W-1:0] TIMEOUT_C = ERR_W'(TIMEOUT);

  // Clamp a cycle count to the positive output range.
  function automatic logic [ERR_W-1:0] clamp_mag(input logic [ERR_W-1:0] c);
    return (c > MAX_POS) ? MAX_POS : c;
  endfunction

  // Two's-complement negate of a clamped magnitude.
  function automatic logic [ERR_W-1:0] neg_mag(input logic [ERR_W-1:0] m);
    return CNT_ZERO - m;
  endfunction

  // Saturating count increment.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == CNT_SAT) ? CNT_SAT : (c + CNT_ONE);
  endfunction

  logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
  logic [SYNC_STAGES-1:0] fb_sync_q,  fb_sync_d;
  logic                   ref_prev_q, ref_prev_d;
  logic                   fb_prev_q,  fb_prev_d;
  logic                   ref_e, fb_e;

  state_t           state_q, state_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] phase_err_q, phase_err_d;
  logic             err_valid_q, err_valid_d;
  logic             timeout_q, timeout_d;

  logic             emit_s;
  logic             emit_to_s;
  logic [ERR_W-1:0] emit_val_s;

  // Synchroniser shift and edge-history next values; these run regardless of en.
  always_comb begin
    ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], ref_in};
    fb_sync_d  = {fb_sync_q[SYNC_STAGES-2:0],  fb_in};
    ref_prev_d = ref_sync_q[SYNC_STAGES-1];
    fb_prev_d  = fb_sync_q[SYNC_STAGES-1];
  end

  assign ref_e = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
  assign fb_e  = fb_sync_q[SYNC_STAGES-1]  & ~fb_prev_q;

  // Measurement FSM: next state, next count and the sample to emit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    emit_s     = 1'b0;
    emit_to_s  = 1'b0;
    emit_val_s = CNT_ZERO;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_e && fb_e) begin
            emit_s     = 1'b1;
            emit_val_s = CNT_ZERO;
          end else if (ref_e) begin
            cnt_d   = CNT_ONE;
            state_d = WAIT_FB;
          end else if (fb_e) begin
            cnt_d   = CNT_ONE;
            state_d = WAIT_REF;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        WAIT_FB: begin
          if (fb_e) begin
            emit_s     = 1'b1;
            emit_val_s = clamp_mag(cnt_q);
            if (ref_e) begin
              cnt_d = CNT_ONE;
            end else begin
              cnt_d   = CNT_ZERO;
              state_d = IDLE;
            end
          end else if (ref_e) begin
            // Cycle slip: a second reference edge before any feedback edge.
            emit_s     = 1'b1;
            emit_to_s  = 1'b1;
            emit_val_s = MAX_POS;
            cnt_d      = CNT_ONE;
          end else if (cnt_q >= TIMEOUT_C) begin
            emit_s     = 1'b1;
            emit_to_s  = 1'b1;
            emit_val_s = MAX_POS;
            cnt_d      = CNT_ZERO;
            state_d    = IDLE;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        WAIT_REF: begin
          if (ref_e) begin
            emit_s     = 1'b1;
            emit_val_s = neg_mag(clamp_mag(cnt_q));
            if (fb_e) begin
              cnt_d = CNT_ONE;
            end else begin
              cnt_d   = CNT_ZERO;
              state_d = IDLE;
            end
          end else if (fb_e) begin
            emit_s     = 1'b1;
            emit_to_s  = 1'b1;
            emit_val_s = neg_mag(MAX_POS);
            cnt_d      = CNT_ONE;
          end else if (cnt_q >= TIMEOUT_C) begin
            emit_s     = 1'b1;
            emit_to_s  = 1'b1;
            emit_val_s = neg_mag(MAX_POS);
            cnt_d      = CNT_ZERO;
            state_d    = IDLE;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output register next values; phase_err holds between strobes.
  always_comb begin
    err_valid_d = emit_s;
    timeout_d   = emit_to_s;
    if (emit_s) begin
      phase_err_d = emit_val_s;
    end else begin
      phase_err_d = phase_err_q;
    end
  end

  // All detector state: synchronisers, FSM, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sync_q  <= '0;
      fb_sync_q   <= '0;
      ref_prev_q  <= 1'b0;
      fb_prev_q   <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      phase_err_q <= CNT_ZERO;
      err_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      ref_sync_q  <= ref_sync_d;
      fb_sync_q   <= fb_sync_d;
      ref_prev_q  <= ref_prev_d;
      fb_prev_q   <= fb_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_err_q <= phase_err_d;
      err_valid_q <= err_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign phase_err = phase_err_q;
  assign err_valid = err_valid_q;
  assign timeout   = timeout_q;

`ifdef ADPLL_LOCK_DET_EN
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] RUN_ZERO = '0;
  localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] TOL_C    = ERR_W'(LOCK_TOL);

  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_inc_s;
  logic [ERR_W-1:0] err_abs_s;
  logic             in_band_s;
  logic             locked_q, locked_d;

  // Lock run counter: counts consecutive in-band strobes, any other strobe clears it.
  always_comb begin
    err_abs_s = phase_err_q[ERR_W-1] ? neg_mag(phase_err_q) : phase_err_q;
    in_band_s = (err_abs_s <= TOL_C) && !timeout_q;
    run_inc_s = (run_q < RUN_MAX) ? (run_q + RUN_ONE) : RUN_MAX;
    run_d     = run_q;
    locked_d  = locked_q;
    if (!en) begin
      run_d    = RUN_ZERO;
      locked_d = 1'b0;
    end else if (err_valid_q) begin
      if (in_band_s) begin
        run_d    = run_inc_s;
        locked_d = (run_inc_s == RUN_MAX);
      end else begin
        run_d    = RUN_ZERO;
        locked_d = 1'b0;
      end
    end else begin
      run_d    = run_q;
      locked_d = locked_q;
    end
  end

  // Lock detector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= RUN_ZERO;
      locked_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule
